// File: rtl/button_pkg.sv
// Shared definitions for the button conditioning block.
// Pure declarations: no logic, no latency.
// No flow control; consumers of btn_vec_t sample levels directly.
package button_pkg;

    localparam int BTN_NUM_DEFAULT = 4;

    typedef logic [BTN_NUM_DEFAULT-1:0] btn_vec_t;

    // Raw pin level when nobody is touching the button.
    function automatic logic idle_lvl(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchronizer, integrating debounce counter, press/release pulses.
// Latency: a clean raw edge reaches pressed 2**CNT_WIDTH + 2 clk later; pulses coincide with it.
// No backpressure: pulses are single-cycle and cannot be stalled. `BUTTON_AUTOREPEAT_EN adds press autorepeat.
module debounce_chan
    import button_pkg::*;
#(
    parameter int CNT_WIDTH  = 18,
    parameter int ACTIVE_LOW = 1
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pressed,
    output logic press,
    output logic release_pulse
);

    localparam logic IDLE = idle_lvl(ACTIVE_LOW != 0);
    localparam logic POL  = (ACTIVE_LOW != 0);

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic                 pressed_q, pressed_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 act;
    logic                 mismatch;
    logic                 commit;
    logic                 rpt_fire;

    always_comb begin
        s1_d      = btn_raw;
        s2_d      = s1_q;
        act       = s2_q ^ POL;
        mismatch  = (act != pressed_q);
        // Saturation is the commit point, so the counter never wraps.
        commit    = mismatch && (&cnt_q);
        cnt_d     = '0;
        if (mismatch && !commit) begin
            cnt_d = cnt_q + 1'b1;
        end
        pressed_d = commit ? act : pressed_q;
        press_d   = (commit && act) || rpt_fire;
        rel_d     = commit && !act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= IDLE;
            s2_q      <= IDLE;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;

    // A commit while held is a release commit: it clears rpt and suppresses any repeat.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (pressed_q && !commit) begin
            if (rpt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign pressed       = pressed_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BUTTONS raw button pins into clean levels plus press/release pulses (release is a reserved word, hence release_pulse).
// Latency: 2**CNT_WIDTH + 2 clk from a clean raw edge to pressed/press/release_pulse.
// No backpressure; channels are independent. `BUTTON_AUTOREPEAT_EN enables press autorepeat.
module button_debounce
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS   = BTN_NUM_DEFAULT,
    parameter int CNT_WIDTH     = 18,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] BUTTON,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_chan #(
            .CNT_WIDTH     (CNT_WIDTH),
            .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef BUTTON_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (BUTTON[i]),
            .pressed       (pressed[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: per-cycle scoreboard against a behavioural model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_button_debounce;
    import button_pkg::*;

    localparam int NB  = 4;
    localparam int CW  = 4;
    localparam int AL  = 1;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int WIN = 1 << CW;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    btn_vec_t        btn   = '1;
    logic [NB-1:0]   pressed, press, rel;

    always #5 clk = ~clk;

    button_debounce #(
        .NUM_BUTTONS   (NB),
        .CNT_WIDTH     (CW),
        .ACTIVE_LOW    (AL),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .BUTTON        (btn),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (rel)
    );

    typedef struct packed {
        logic [NB-1:0] pr;
        logic [NB-1:0] ps;
        logic [NB-1:0] rl;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   press_cnt[NB];
    int   rel_cnt[NB];
    int   all_press_seen = 0;

    // Reference: a level commits once the synced input has disagreed with it for WIN
    // consecutive cycles; the synced input is the raw pin two edges late.
    initial begin : model
        logic [NB-1:0] pin_d1, pin_d2, lvl, act;
        obs_t o;
        int   run[NB];
        int   held[NB];
        pin_d1 = AL ? '1 : '0;
        pin_d2 = pin_d1;
        lvl    = '0;
        for (int i = 0; i < NB; i++) begin
            run[i]  = 0;
            held[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            o = '0;
            if (rst_n !== 1'b1) begin
                pin_d1 = AL ? '1 : '0;
                pin_d2 = pin_d1;
                lvl    = '0;
                for (int i = 0; i < NB; i++) begin
                    run[i]  = 0;
                    held[i] = 0;
                end
            end else begin
                act    = AL ? ~pin_d2 : pin_d2;
                pin_d2 = pin_d1;
                pin_d1 = btn;
                for (int i = 0; i < NB; i++) begin
                    if (act[i] == lvl[i]) begin
                        run[i] = 0;
`ifdef BUTTON_AUTOREPEAT_EN
                        if (lvl[i]) begin
                            held[i]++;
                            if (held[i] >= RD && (held[i] - RD) % RP == 0) o.ps[i] = 1'b1;
                        end
`endif
                    end else begin
                        run[i]++;
                        if (run[i] == WIN) begin
                            lvl[i]  = act[i];
                            run[i]  = 0;
                            held[i] = 0;
                            if (act[i]) o.ps[i] = 1'b1;
                            else        o.rl[i] = 1'b1;
                        end
`ifdef BUTTON_AUTOREPEAT_EN
                        else if (lvl[i]) begin
                            held[i]++;
                            if (held[i] >= RD && (held[i] - RD) % RP == 0) o.ps[i] = 1'b1;
                        end
`endif
                    end
                end
            end
            o.pr = lvl;
            exp_q.push_back(o);
        end
    end

    initial begin : monitor
        obs_t got, want;
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            got = {pressed, press, rel};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty cycle %0d: got %b/%b/%b with no expectation",
                         cyc, pressed, press, rel);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL cycle %0d pressed/press/release: got %b/%b/%b want %b/%b/%b",
                             cyc, got.pr, got.ps, got.rl, want.pr, want.ps, want.rl);
                end
            end
            for (int i = 0; i < NB; i++) begin
                press_cnt[i] += int'(press[i] === 1'b1);
                rel_cnt[i]   += int'(rel[i] === 1'b1);
            end
            if (press === '1) all_press_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Bounded wait for pressed[ch] to reach lv; reports edges elapsed since start.
    task automatic wait_level(input int ch, input logic lv, input int start, input string name);
        int lat;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (pressed[ch] === lv) begin
                lat = cyc - start;
                break;
            end
        end
        #1;
        check(name, lat, WIN + 2);
    endtask

    initial begin : stim
        int t0, pc, rc, ap;
        btn   = '1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(40);

        pc = press_cnt[0];
        btn[0] = 1'b0;
        t0 = cyc;
        wait_level(0, 1'b1, t0, "t2_press_latency");
        tick(2);
        check("t2_press_pulses", press_cnt[0] - pc, 1);

        pc = press_cnt[1];
        for (int k = 0; k < 12; k++) begin
            btn[1] = ~btn[1];
            tick(5);
        end
        check("t3_bounce_pulses", press_cnt[1] - pc, 0);
        btn[1] = 1'b0;
        t0 = cyc;
        wait_level(1, 1'b1, t0, "t3_press_latency");
        tick(2);
        check("t3_press_pulses", press_cnt[1] - pc, 1);

        rc = rel_cnt[0];
        btn[0] = 1'b1;
        tick(10);
        btn[0] = 1'b0;
        tick(30);
        check("t4_glitch_releases", rel_cnt[0] - rc, 0);
        btn[0] = 1'b1;
        t0 = cyc;
        wait_level(0, 1'b0, t0, "t4_release_latency");
        tick(2);
        check("t4_release_pulses", rel_cnt[0] - rc, 1);

        btn = '1;
        tick(25);
        ap = all_press_seen;
        btn = '0;
        tick(25);
        check("t5_simultaneous_press", all_press_seen - ap, 1);
        btn = '1;
        tick(25);

        pc = press_cnt[3];
        btn[3] = 1'b0;
        tick(11);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        t0 = cyc;
        wait_level(3, 1'b1, t0, "t5_reset_restart_latency");
        tick(2);
        check("t5_reset_press_pulses", press_cnt[3] - pc, 1);
        btn = '1;
        tick(25);

`ifdef BUTTON_AUTOREPEAT_EN
        pc = press_cnt[2];
        rc = rel_cnt[2];
        btn[2] = 1'b0;
        tick(75);
        btn[2] = 1'b1;
        tick(30);
        check("t6_repeat_presses", press_cnt[2] - pc, 5);
        check("t6_release_pulses", rel_cnt[2] - rc, 1);
`endif

        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            end
            if (rst_n && $urandom_range(0, 399) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
            tick(1);
        end
        rst_n = 1'b1;
        btn = '1;
        tick(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
